mysystem_result_to_hps: RTL and testbench
=========================================

MYSYSTEM_RESULT_TO_HPS -- requirements
Module: mysystem_result_to_hps

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, the width of the FPGA-side result word (1..16).
REQ-002 The block SHALL have input clk, 1 bit, the single clock for all logic.
REQ-003 The block SHALL have input reset_n, 1 bit, the asynchronous active-low reset.
REQ-004 The block SHALL have input address, 2 bits, the Avalon-MM word address.
REQ-005 The block SHALL have input chipselect, 1 bit, the Avalon-MM slave select.
REQ-006 The block SHALL have input read_n, 1 bit, the active-low read strobe.
REQ-007 The block SHALL have input write_n, 1 bit, the active-low write strobe.
REQ-008 The block SHALL have input writedata, 32 bits, the Avalon-MM write data.
REQ-009 The block SHALL have output readdata, 32 bits, the Avalon-MM read data, combinational and zero wait state.
REQ-010 The block SHALL have input in_strobe, 1 bit, a single-cycle FPGA-side pulse marking in_data as valid.
REQ-011 The block SHALL have input in_data, DATA_W bits, the FPGA-side result word.
REQ-012 The block SHALL have output in_empty, 1 bit, high when the holding register is empty.
REQ-013 The block SHALL have output irq, 1 bit, the level interrupt to the HPS.

Function
REQ-014 Register map SHALL be: 0 DATA (read-only), 1 STATUS, 2 IRQMASK, 3 LIVE (read-only), with all unused readdata bits reading 0.
REQ-015 DATA SHALL read hold_reg zero-extended to 32 bits.
REQ-016 STATUS SHALL read bit0 = full, bit1 = overrun, bits[15:8] = drop_cnt.
REQ-017 IRQMASK SHALL read bit0 = full interrupt enable and bit1 = overrun interrupt enable.
REQ-018 LIVE SHALL read the current in_data, zero-extended, with no side effect.
REQ-019 A pop SHALL occur when chipselect, ~read_n and address==0 are all true; a pop clears full on the next edge.
REQ-020 A pop while empty SHALL be harmless: DATA returns the stale hold_reg and full stays 0.
REQ-021 A capture SHALL occur when in_strobe is high and either full==0 or a pop occurs in the same cycle; hold_reg then loads in_data and full is 1 after the edge.
REQ-022 On a simultaneous pop and capture, readdata SHALL return the old hold_reg, hold_reg SHALL load the new word, and full SHALL remain 1.
REQ-023 When in_strobe is high, full==1 and no pop occurs, the word SHALL be dropped, overrun SHALL be set (sticky), and drop_cnt SHALL increment, saturating at 255.
REQ-024 A write to STATUS with writedata bit1==1 SHALL clear overrun and drop_cnt; if a drop occurs in the same cycle, overrun SHALL end at 1 and drop_cnt at 1.
REQ-025 A write to STATUS with bit1==0 SHALL have no effect.
REQ-026 Writes to DATA and LIVE SHALL be ignored.
REQ-027 in_empty SHALL equal ~full, as a registered-state output.
REQ-028 irq SHALL equal (full & mask[0]) | (overrun & mask[1]), combinational from registers.
REQ-029 A read of STATUS, IRQMASK or LIVE SHALL have no side effect.

Reset
REQ-030 On reset_n low, hold_reg, full, overrun, drop_cnt and mask SHALL clear asynchronously to 0.
REQ-031 While reset is asserted, in_empty SHALL be 1 and irq SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard any held word without setting overrun.
REQ-033 Reset release SHALL be synchronous to clk by the system reset controller.

Configuration
REQ-034 With macro RESULT_TO_HPS_IRQ_EN defined, the IRQMASK register and the irq logic SHALL be present as specified in REQ-017 and REQ-028.
REQ-035 Without RESULT_TO_HPS_IRQ_EN, IRQMASK SHALL read 0, writes to it SHALL be ignored, and irq SHALL be tied 0.
REQ-036 Without RESULT_TO_HPS_IRQ_EN, all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset then read all four registers -> DATA=0, STATUS=0, IRQMASK=0, LIVE=in_data; in_empty=1; irq=0.
REQ-038 in_strobe with in_data=0x1234, then read DATA -> readdata=0x00001234; STATUS.full=1 before the pop and 0 after; in_empty returns to 1.
REQ-039 Capture 0x0001, then strobe 0x0002 and 0x0003 with no pop -> DATA=0x0001; STATUS=0x0203; write STATUS=0x2 -> STATUS=0x0001.
REQ-040 Held 0x00AA, pop and strobe 0x00BB in the same cycle -> that read returns 0x00AA, full stays 1, and the next DATA read returns 0x00BB.
REQ-041 300 strobes while full with no pop -> drop_cnt=255 (STATUS[15:8]=0xFF), overrun=1.
REQ-042 With RESULT_TO_HPS_IRQ_EN, IRQMASK=0x1 and then one capture -> irq=1 one cycle after the strobe, and irq=0 one cycle after the pop; without the macro -> irq=0 throughout and IRQMASK reads 0.

Source files
------------

// File: rtl/mysystem_result_to_hps.sv
// mysystem_result_to_hps: single-word holding register between an FPGA-side
// result producer and an HPS Avalon-MM slave port.
// The FPGA side strobes a result word in. The HPS pops it by reading DATA.
// Words that arrive while the slot is occupied are dropped and counted.
// Optional feature: define RESULT_TO_HPS_IRQ_EN to add the IRQMASK register
// and the level interrupt. Without it, IRQMASK reads 0 and irq is tied 0.
module mysystem_result_to_hps #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              in_strobe,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_empty,
  output logic              irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_LIVE    = 2'd3;
  localparam int         PAD_W        = 32 - DATA_W;

  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic pop, capture, drop, status_clr, wr_strobe;

  // Decode bus strobes and the capture/drop decision for this cycle.
  always_comb begin
    wr_strobe  = chipselect & ~write_n;
    pop        = chipselect & ~read_n & (address == ADDR_DATA);
    // A pop in the same cycle frees the slot, so the new word is still taken.
    capture    = in_strobe & (~full_q | pop);
    drop       = in_strobe & full_q & ~pop;
    status_clr = wr_strobe & (address == ADDR_STATUS) & writedata[1];
  end

  // Next-state logic for the holding register and the overrun bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a latch.
    hold_d     = hold_q;
    full_d     = full_q;
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;

    if (capture) begin
      hold_d = in_data;
      full_d = 1'b1;
    end else if (pop) begin
      full_d = 1'b0;
    end

    // The clear is applied first. A drop in the same cycle then counts as the first new drop.
    if (status_clr) begin
      overrun_d  = 1'b0;
      drop_cnt_d = 8'd0;
    end
    if (drop) begin
      overrun_d = 1'b1;
      if (drop_cnt_d != 8'hFF) drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  // State registers; the held word is discarded on reset without flagging overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments, so all registers update together.
    if (!reset_n) begin
      hold_q     <= '0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      hold_q     <= hold_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  logic [1:0] mask_rd;

`ifdef RESULT_TO_HPS_IRQ_EN
  logic [1:0] mask_q, mask_d;

  // IRQMASK write decode.
  always_comb begin
    mask_d = mask_q;
    if (wr_strobe && (address == ADDR_IRQMASK)) mask_d = writedata[1:0];
  end

  // Interrupt mask register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mask_q <= 2'b00;
    else          mask_q <= mask_d;
  end

  assign mask_rd = mask_q;
  assign irq     = (full_q & mask_q[0]) | (overrun_q & mask_q[1]);
`else
  assign mask_rd = 2'b00;
  assign irq     = 1'b0;
`endif

  assign in_empty = ~full_q;

  // Only some writedata bits are decoded; the rest are intentionally ignored.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Zero-wait-state read mux; reads never change state except the DATA pop.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_DATA:    readdata = {{PAD_W{1'b0}}, hold_q};
      ADDR_STATUS:  readdata = {16'd0, drop_cnt_q, 6'd0, overrun_q, full_q};
      ADDR_IRQMASK: readdata = {30'd0, mask_rd};
      ADDR_LIVE:    readdata = {{PAD_W{1'b0}}, in_data};
      default:      readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mysystem_result_to_hps.sv
// Testbench for mysystem_result_to_hps (DATA_W = 16).
// Directed stimulus with literal expectations, plus an event-level model that
// is checked against readdata, in_empty and irq on every falling edge.
module tb_mysystem_result_to_hps;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        in_strobe = 1'b0;
  logic [15:0] in_data = 16'h5A5A;
  logic        in_empty;
  logic        irq;

  int errors = 0;
  int checks = 0;

  mysystem_result_to_hps #(.DATA_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_strobe  (in_strobe),
    .in_data    (in_data),
    .in_empty   (in_empty),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The slot holds at most one word. A strobe takes the slot if it is free or
  // being freed by a pop. Otherwise the word is lost and counted. A STATUS clear
  // happens before this cycle's loss is counted.
  logic [15:0] m_hold = '0;
  logic        m_full = 1'b0;
  logic        m_ovr  = 1'b0;
  int          m_drops = 0;
  logic [1:0]  m_mask = 2'b00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_hold = '0; m_full = 1'b0; m_ovr = 1'b0; m_drops = 0; m_mask = 2'b00;
    end else begin
      bit rd_data, wr_any;
      rd_data = chipselect && !read_n && address == 2'd0;
      wr_any  = chipselect && !write_n;
      if (wr_any && address == 2'd1 && writedata[1]) begin
        m_ovr = 1'b0; m_drops = 0;
      end
`ifdef RESULT_TO_HPS_IRQ_EN
      if (wr_any && address == 2'd2) m_mask = writedata[1:0];
`endif
      if (in_strobe) begin
        if (!m_full || rd_data) begin
          m_hold = in_data; m_full = 1'b1;
        end else begin
          m_ovr = 1'b1;
          m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
        end
      end else if (rd_data) begin
        m_full = 1'b0;
      end
    end
  end

  function automatic logic [31:0] model_readdata();
    logic [7:0] cnt8;
    cnt8 = 8'(m_drops);
    case (address)
      2'd0:    return {16'd0, m_hold};
      2'd1:    return {16'd0, cnt8, 6'd0, m_ovr, m_full};
      2'd2:    return {30'd0, m_mask};
      default: return {16'd0, in_data};
    endcase
  endfunction

  bit model_on = 1'b0;

  // Compare DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      logic m_irq;
`ifdef RESULT_TO_HPS_IRQ_EN
      m_irq = (m_full & m_mask[0]) | (m_ovr & m_mask[1]);
`else
      m_irq = 1'b0;
`endif
      check("model readdata", readdata, model_readdata());
      check("model in_empty", {31'd0, in_empty}, {31'd0, !m_full});
      check("model irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; in_strobe = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Read a register (optionally alongside a strobe set up by the caller).
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    @(negedge clk);
    check(name, readdata, exp);
    next_cycle();
    idle();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    next_cycle();
    idle();
  endtask

  task automatic strobe(input logic [15:0] d);
    in_strobe = 1'b1; in_data = d;
    next_cycle();
    idle();
  endtask

  task automatic chk_out(input string name, input logic exp_empty, input logic exp_irq);
    @(negedge clk);
    check({name, " in_empty"}, {31'd0, in_empty}, {31'd0, exp_empty});
    check({name, " irq"}, {31'd0, irq}, {31'd0, exp_irq});
    next_cycle();
  endtask

  initial begin
    idle();
    model_on = 1'b1;
    repeat (2) next_cycle();
    chk_out("in reset", 1'b1, 1'b0);
    reset_n = 1'b1;

    // Reset state of every register.
    rd(2'd0, 32'h0000_0000, "reset DATA");
    rd(2'd1, 32'h0000_0000, "reset STATUS");
    rd(2'd2, 32'h0000_0000, "reset IRQMASK");
    rd(2'd3, 32'h0000_5A5A, "reset LIVE");
    chk_out("after reset", 1'b1, 1'b0);

    // Single capture and pop.
    strobe(16'h1234);
    rd(2'd1, 32'h0000_0001, "full before pop");
    rd(2'd0, 32'h0000_1234, "pop 1234");
    rd(2'd1, 32'h0000_0000, "empty after pop");
    chk_out("after pop", 1'b1, 1'b0);

    // Overrun: the first word is kept and the next two are dropped.
    strobe(16'h0001);
    strobe(16'h0002);
    strobe(16'h0003);
    rd(2'd1, 32'h0000_0203, "STATUS two drops");
    wr(2'd1, 32'h0000_0001);
    rd(2'd1, 32'h0000_0203, "STATUS bit1=0 no effect");
    wr(2'd1, 32'h0000_0002);
    rd(2'd1, 32'h0000_0001, "STATUS cleared");
    wr(2'd0, 32'h0000_DEAD);
    wr(2'd3, 32'h0000_BEEF);
    rd(2'd0, 32'h0000_0001, "DATA kept first word");
    rd(2'd1, 32'h0000_0000, "STATUS after pop");

    // Simultaneous pop and capture.
    strobe(16'h00AA);
    in_strobe = 1'b1; in_data = 16'h00BB;
    rd(2'd0, 32'h0000_00AA, "pop+capture old word");
    rd(2'd1, 32'h0000_0001, "full stays 1");
    rd(2'd0, 32'h0000_00BB, "next pop new word");

    // Pop while empty returns stale data and changes nothing.
    rd(2'd0, 32'h0000_00BB, "empty pop stale");
    rd(2'd1, 32'h0000_0000, "empty pop STATUS");
    rd(2'd3, 32'h0000_00BB, "LIVE shows in_data");

    // Drop counter saturation.
    strobe(16'h0077);
    for (int i = 0; i < 300; i++) begin
      in_strobe = 1'b1; in_data = 16'(i);
      next_cycle();
    end
    idle();
    rd(2'd1, 32'h0000_FF03, "drop_cnt saturates");
    rd(2'd2, 32'h0000_0000, "IRQMASK untouched");
    in_strobe = 1'b1; in_data = 16'h0999;
    wr(2'd1, 32'h0000_0002);
    rd(2'd1, 32'h0000_0103, "clear with same-cycle drop");
    rd(2'd0, 32'h0000_0077, "DATA after saturation");
    wr(2'd1, 32'h0000_0002);
    rd(2'd1, 32'h0000_0000, "STATUS clean");

    // Interrupt behaviour.
`ifdef RESULT_TO_HPS_IRQ_EN
    wr(2'd2, 32'h0000_0001);
    rd(2'd2, 32'h0000_0001, "IRQMASK readback");
    chk_out("masked idle", 1'b1, 1'b0);
    strobe(16'h0042);
    chk_out("irq after capture", 1'b0, 1'b1);
    rd(2'd0, 32'h0000_0042, "irq pop");
    chk_out("irq after pop", 1'b1, 1'b0);
    wr(2'd2, 32'h0000_0002);
    strobe(16'h0043);
    chk_out("ovr mask full only", 1'b0, 1'b0);
    strobe(16'h0044);
    chk_out("irq on overrun", 1'b0, 1'b1);
    wr(2'd1, 32'h0000_0002);
    chk_out("irq overrun cleared", 1'b0, 1'b0);
    rd(2'd0, 32'h0000_0043, "ovr test pop");
    wr(2'd2, 32'h0000_0003);
`else
    wr(2'd2, 32'h0000_0003);
    rd(2'd2, 32'h0000_0000, "IRQMASK reads 0");
    strobe(16'h0042);
    chk_out("no irq after capture", 1'b0, 1'b0);
    strobe(16'h0043);
    chk_out("no irq on overrun", 1'b0, 1'b0);
    rd(2'd1, 32'h0000_0103, "STATUS without irq");
    rd(2'd0, 32'h0000_0042, "pop without irq");
    wr(2'd1, 32'h0000_0002);
`endif

    // Reset mid-operation discards the word without flagging overrun.
    strobe(16'h0055);
    strobe(16'h0066);
    reset_n = 1'b0;
    chk_out("mid-op reset", 1'b1, 1'b0);
    reset_n = 1'b1;
    rd(2'd1, 32'h0000_0000, "STATUS after mid reset");
    rd(2'd0, 32'h0000_0000, "DATA after mid reset");
    rd(2'd2, 32'h0000_0000, "IRQMASK after mid reset");

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
